// File: rtl/rr_arb10.sv
// rtl/rr_arb10.sv - round-robin arbiter driving the select of a 10:1 result mux
// Registered one-hot grant and select, valid/ready toward a single consumer, optional bounded bursts.
module rr_arb10 #(
    parameter int NREQ      = 10,
    parameter int SELW      = 4,
    parameter int MAX_BURST = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            beat_done
);

    localparam int CNTW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int IW   = SELW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [CNTW-1:0] beat_cnt;

    logic            handshake;
    logic [SELW-1:0] rot_ptr;
    logic [SELW-1:0] search_start;
    logic            found;
    logic [SELW-1:0] win;
    logic [IW-1:0]   idx_w;
    logic [31:0]     cnt_plus_one;
    logic            burst_ok;

    assign handshake    = out_valid && out_ready;
    assign beat_done    = handshake;
    assign rot_ptr      = (sel == SELW'(NREQ - 1)) ? '0 : sel + SELW'(1);
    // In GRANT the search only matters on a handshake, where it must start past the current winner.
    assign search_start = (state == GRANT) ? rot_ptr : ptr;
    assign cnt_plus_one = 32'(beat_cnt) + 32'd1;
    assign burst_ok     = req[sel] && (cnt_plus_one < 32'(MAX_BURST));

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx_w = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, search_start} + IW'(k);
            if (idx_w >= IW'(NREQ)) begin
                idx_w = idx_w - IW'(NREQ);
            end
            if (!found && req[idx_w[SELW-1:0]]) begin
                found = 1'b1;
                win   = idx_w[SELW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        sel       <= win;
                        out_valid <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        if (burst_ok) begin
                            beat_cnt <= beat_cnt + CNTW'(1);
                        end else begin
                            ptr      <= rot_ptr;
                            beat_cnt <= '0;
                            if (found) begin
                                grant <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                                sel   <= win;
                            end else begin
                                grant     <= '0;
                                out_valid <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb10.sv
// tb/tb_rr_arb10.sv - scoreboard bench for rr_arb10 with MAX_BURST=1 and MAX_BURST=4 instances
// A cycle-level reference model predicts each accepted beat; a negedge monitor pops and compares.
module tb_rr_arb10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] req = '0;
    logic       out_ready = 1'b0;

    logic [9:0] grant1, grant4;
    logic [3:0] sel1, sel4;
    logic       ov1, ov4, bd1, bd4;

    always #5 clk = ~clk;

    rr_arb10 #(.NREQ(10), .SELW(4), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant1), .sel(sel1),
        .out_valid(ov1), .out_ready(out_ready), .beat_done(bd1)
    );

    rr_arb10 #(.NREQ(10), .SELW(4), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant4), .sel(sel4),
        .out_valid(ov4), .out_ready(out_ready), .beat_done(bd4)
    );

    int total = 0;
    int bad   = 0;
    int q1[$];
    int q4[$];
    int m_cur[2];
    int m_ptr[2];
    int m_cnt[2];
    int mb[2] = '{1, 4};
    bit exp_valid[2];
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, want, $time);
        end
    endtask

    // Winner = first requester at or after p, counting upward modulo 10.
    function automatic int first_req(input logic [9:0] r, input int p);
        for (int k = 0; k < 10; k++) begin
            if (r[(p + k) % 10]) return (p + k) % 10;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cur[d] = -1;
            m_ptr[d] = 0;
            m_cnt[d] = 0;
            exp_valid[d] = 1'b0;
        end
        q1.delete();
        q4.delete();
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = (m_cur[d] >= 0);
            if (m_cur[d] < 0) begin
                m_cur[d] = first_req(req, m_ptr[d]);
                m_cnt[d] = 0;
            end else if (out_ready) begin
                if (d == 0) q1.push_back(m_cur[d]);
                else        q4.push_back(m_cur[d]);
                if (req[m_cur[d]] && (m_cnt[d] + 1 < mb[d])) begin
                    m_cnt[d]++;
                end else begin
                    m_ptr[d] = (m_cur[d] + 1) % 10;
                    m_cur[d] = first_req(req, m_ptr[d]);
                    m_cnt[d] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [9:0] r, input logic rdy);
        @(posedge clk);
        #1;
        req = r;
        out_ready = rdy;
        model_step();
    endtask

    task automatic mon_dut(input int d, input logic [9:0] g, input logic [3:0] s,
                           input logic v, input logic bd);
        int e;
        check($sformatf("valid%0d", d), int'(v), int'(exp_valid[d]));
        check($sformatf("beat_done%0d", d), int'(bd), int'(v && out_ready));
        check($sformatf("grant_onehot%0d", d), int'(g), v ? (1 << s) : 0);
        check($sformatf("sel_range%0d", d), (s < 4'd10) ? 1 : 0, 1);
        if (v && out_ready) begin
            if ((d == 0 && q1.size() == 0) || (d == 1 && q4.size() == 0)) begin
                check($sformatf("beat_expected%0d", d), 1, 0);
            end else begin
                e = (d == 0) ? q1.pop_front() : q4.pop_front();
                check($sformatf("beat_sel%0d", d), int'(s), e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_dut(0, grant1, sel1, ov1, bd1);
            mon_dut(1, grant4, sel4, ov4, bd4);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_grant", int'(grant1), 0);
        check("rst_sel", int'(sel4), 0);
        check("rst_valid", int'(ov1 | ov4), 0);
        #2;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // idle and one-cycle latency
        repeat (3) step(10'h000, 1'b1);
        step(10'h020, 1'b0);
        step(10'h020, 1'b0);
        check("lat_sel5", int'(sel1), 5);
        step(10'h000, 1'b1);
        repeat (2) step(10'h000, 1'b1);

        // fairness
        repeat (14) step(10'h3FF, 1'b1);
        repeat (6) step(10'h000, 1'b1);

        // backpressure with the request dropped while frozen
        step(10'h008, 1'b0);
        step(10'h008, 1'b0);
        repeat (3) step(10'h000, 1'b0);
        step(10'h000, 1'b1);
        repeat (2) step(10'h000, 1'b1);

        // bursts, then an early drop of req[2]
        repeat (10) step(10'h084, 1'b1);
        repeat (4) step(10'h000, 1'b1);
        step(10'h084, 1'b1);
        step(10'h084, 1'b1);
        step(10'h084, 1'b1);
        repeat (6) step(10'h080, 1'b1);
        repeat (4) step(10'h000, 1'b1);

        // wrap 9 -> 0 -> 8
        step(10'h200, 1'b1);
        step(10'h200, 1'b1);
        repeat (10) step(10'h101, 1'b1);
        repeat (6) step(10'h000, 1'b1);

        // asynchronous reset mid-grant
        step(10'h040, 1'b0);
        step(10'h040, 1'b0);
        check("pre_rst_sel6", int'(sel1), 6);
        #2;
        req = '0;
        rst_n = 1'b0;
        #1;
        check("arst_grant", int'(grant1 | grant4), 0);
        check("arst_sel", int'(sel1 | sel4), 0);
        check("arst_valid", int'(ov1 | ov4), 0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(10'h040, 1'b0);
        step(10'h040, 1'b0);
        check("post_rst_sel6", int'(sel4), 6);
        check("post_rst_valid", int'(ov4), 1);
        step(10'h000, 1'b1);

        // randomized traffic
        for (int blk = 0; blk < 30; blk++) begin
            int dens;
            dens = $urandom_range(0, 3);
            for (int c = 0; c < 80; c++) begin
                logic [9:0] r;
                case (dens)
                    0: r = 10'($urandom) & 10'($urandom) & 10'($urandom);
                    1: r = 10'($urandom);
                    2: r = 10'($urandom) | 10'($urandom);
                    default: r = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'h3FF;
                endcase
                step(r, $urandom_range(0, 3) != 0);
            end
        end

        repeat (12) step(10'h000, 1'b1);
        @(negedge clk);
        #1;
        check("q1_drained", q1.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
